// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: single-outstanding request/response.
// Valid/ready: a request transfers on a cycle where ImemReq=1 and ImemAck=1; a response transfers on any cycle with ImemRValid=1 (no backpressure).
interface fetch_unit_if #(
  parameter int SIZE = 32
);
  logic            ImemReq;
  logic [SIZE-1:0] ImemAddr;
  logic            ImemAck;
  logic [SIZE-1:0] ImemRData;
  logic            ImemRValid;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemAck, ImemRData, ImemRValid
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemAck, ImemRData, ImemRValid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, buffers one returned instruction,
// holds it under StallF and redirects on taken branches, draining stale responses.
module fetch_unit #(
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            StallF,
  input  logic            BranchTakenE,
  input  logic [SIZE-1:0] BranchTargetE,
  fetch_unit_if.master    imem,
  output logic [SIZE-1:0] InstrF,
  output logic [SIZE-1:0] PCF,
  output logic [SIZE-1:0] PCPlus4F,
  output logic            ValidF,
  output logic            MissF,
  output logic [1:0]      DbgStateF
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] req_pc_q, req_pc_d;
  logic [SIZE-1:0] instr_buf_q, instr_buf_d;
  logic [SIZE-1:0] pcf_q, pcf_d;
  logic            buf_valid_q, buf_valid_d;
  logic            imem_req;
  logic            consume;

  // A new request may go out in the same cycle the buffered instruction is consumed.
  assign imem_req = (state_q == FETCH) & ~BranchTakenE & (~buf_valid_q | ~StallF);
  assign consume  = buf_valid_q & ~StallF;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    instr_buf_d = instr_buf_q;
    pcf_d       = pcf_q;
    buf_valid_d = buf_valid_q;

    if (BranchTakenE) begin
      // Redirect wins over stall and over any response arriving this cycle.
      pc_d        = BranchTargetE;
      buf_valid_d = 1'b0;
      case (state_q)
        WAIT:    state_d = imem.ImemRValid ? FETCH : DRAIN;
        DRAIN:   state_d = imem.ImemRValid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      if (consume) buf_valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_req && imem.ImemAck) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + SIZE'(4);
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem.ImemRValid) begin
            instr_buf_d = imem.ImemRData;
            pcf_d       = req_pc_q;
            buf_valid_d = 1'b1;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          if (imem.ImemRValid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      instr_buf_q <= '0;
      pcf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      instr_buf_q <= instr_buf_d;
      pcf_q       <= pcf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem.ImemReq  = imem_req;
  assign imem.ImemAddr = pc_q;
  assign InstrF        = buf_valid_q ? instr_buf_q : '0;
  assign PCF           = pcf_q;
  assign PCPlus4F      = pcf_q + SIZE'(4);
  assign ValidF        = buf_valid_q;
  assign MissF         = ~buf_valid_q;
  assign DbgStateF     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances, one with RESET_PC=0 and one
// with RESET_PC=32'hFFFF_FFFC to exercise PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br;
  logic [31:0] tgt;
  logic        b_stall, b_br;
  logic [31:0] b_tgt;

  logic [31:0] instr_f, pcf, pcp4;
  logic        valid_f, miss_f;
  logic [1:0]  dbg;
  logic [31:0] b_instr_f, b_pcf, b_pcp4;
  logic        b_valid_f, b_miss_f;
  logic [1:0]  b_dbg;

  int errors = 0;
  int checks = 0;

  fetch_unit_if #(.SIZE(32)) ifa ();
  fetch_unit_if #(.SIZE(32)) ifb ();

  fetch_unit #(.SIZE(32), .RESET_PC(32'h0000_0000)) dut_a (
    .CLK(clk), .RST_N(rst_n), .StallF(stall), .BranchTakenE(br),
    .BranchTargetE(tgt), .imem(ifa), .InstrF(instr_f), .PCF(pcf),
    .PCPlus4F(pcp4), .ValidF(valid_f), .MissF(miss_f), .DbgStateF(dbg)
  );

  fetch_unit #(.SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .CLK(clk), .RST_N(rst_n), .StallF(b_stall), .BranchTakenE(b_br),
    .BranchTargetE(b_tgt), .imem(ifb), .InstrF(b_instr_f), .PCF(b_pcf),
    .PCPlus4F(b_pcp4), .ValidF(b_valid_f), .MissF(b_miss_f), .DbgStateF(b_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(ifa.ImemReq), 32'd1);
    chk({tag, "_addr"},  ifa.ImemAddr,     32'h0);
    chk({tag, "_instr"}, instr_f,          32'h0);
    chk({tag, "_valid"}, 32'(valid_f),     32'd0);
    chk({tag, "_miss"},  32'(miss_f),      32'd1);
    chk({tag, "_pcf"},   pcf,              32'h0);
    chk({tag, "_pcp4"},  pcp4,             32'h4);
    chk({tag, "_state"}, 32'(dbg),         32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; br = 1'b0; tgt = 32'h0;
    b_stall = 1'b0; b_br = 1'b0; b_tgt = 32'h0;
    ifa.ImemAck = 1'b0; ifa.ImemRValid = 1'b0; ifa.ImemRData = 32'h0;
    ifb.ImemAck = 1'b0; ifb.ImemRValid = 1'b0; ifb.ImemRData = 32'h0;

    // Reset values
    @(negedge clk); #1;
    chk_reset_outputs("rst");
    chk("rst_b_addr", ifb.ImemAddr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming with a 1-cycle memory, no stall
    for (int i = 0; i < 3; i++) begin
      ifa.ImemAck = 1'b1; ifa.ImemRValid = 1'b0;
      #1;
      chk("seq_req",  32'(ifa.ImemReq), 32'd1);
      chk("seq_addr", ifa.ImemAddr, 32'(4 * i));
      if (i > 0) begin
        chk("seq_valid", 32'(valid_f), 32'd1);
        chk("seq_pcf",   pcf, 32'(4 * (i - 1)));
        chk("seq_instr", instr_f, dat(32'(4 * (i - 1))));
      end
      @(negedge clk);
      ifa.ImemAck = 1'b0; ifa.ImemRValid = 1'b1; ifa.ImemRData = dat(32'(4 * i));
      #1;
      chk("seq_wait_req",   32'(ifa.ImemReq), 32'd0);
      chk("seq_wait_valid", 32'(valid_f), 32'd0);
      chk("seq_wait_state", 32'(dbg), 32'd1);
      @(negedge clk);
    end

    // Stall holds the buffered instruction and blocks new requests
    ifa.ImemRValid = 1'b0; ifa.ImemAck = 1'b1; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req",   32'(ifa.ImemReq), 32'd0);
      chk("stall_valid", 32'(valid_f), 32'd1);
      chk("stall_instr", instr_f, dat(32'h8));
      chk("stall_pcf",   pcf, 32'h8);
      chk("stall_miss",  32'(miss_f), 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("unstall_req",  32'(ifa.ImemReq), 32'd1);
    chk("unstall_addr", ifa.ImemAddr, 32'hC);
    @(negedge clk);

    // Redirect while in WAIT; stale response returns three cycles later
    ifa.ImemAck = 1'b0; br = 1'b1; tgt = 32'h100;
    #1;
    chk("brw_req",   32'(ifa.ImemReq), 32'd0);
    chk("brw_state", 32'(dbg), 32'd1);
    @(negedge clk);
    br = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drain_state", 32'(dbg), 32'd2);
      chk("drain_req",   32'(ifa.ImemReq), 32'd0);
      chk("drain_addr",  ifa.ImemAddr, 32'h100);
      @(negedge clk);
    end
    ifa.ImemRValid = 1'b1; ifa.ImemRData = 32'hDEAD_BEEF;
    #1;
    chk("drain_rv_req", 32'(ifa.ImemReq), 32'd0);
    @(negedge clk);
    ifa.ImemRValid = 1'b0; ifa.ImemAck = 1'b1;
    #1;
    chk("post_drain_valid", 32'(valid_f), 32'd0);
    chk("post_drain_instr", instr_f, 32'h0);
    chk("post_drain_req",   32'(ifa.ImemReq), 32'd1);
    chk("post_drain_addr",  ifa.ImemAddr, 32'h100);
    @(negedge clk);
    ifa.ImemAck = 1'b0; ifa.ImemRValid = 1'b1; ifa.ImemRData = dat(32'h100);
    #1;
    @(negedge clk);
    ifa.ImemRValid = 1'b0; stall = 1'b1;
    #1;
    chk("tgt_valid", 32'(valid_f), 32'd1);
    chk("tgt_pcf",   pcf, 32'h100);
    chk("tgt_instr", instr_f, dat(32'h100));
    chk("tgt_pcp4",  pcp4, 32'h104);
    @(negedge clk);

    // Redirect overrides stall and clears the buffer
    br = 1'b1; tgt = 32'h200;
    #1;
    chk("brs_req", 32'(ifa.ImemReq), 32'd0);
    @(negedge clk);
    br = 1'b0; ifa.ImemAck = 1'b1;
    #1;
    chk("brs_valid", 32'(valid_f), 32'd0);
    chk("brs_instr", instr_f, 32'h0);
    chk("brs_req2",  32'(ifa.ImemReq), 32'd1);
    chk("brs_addr",  ifa.ImemAddr, 32'h200);
    @(negedge clk);

    // Redirect in the same cycle as the response: response dropped
    stall = 1'b0; ifa.ImemAck = 1'b0;
    br = 1'b1; tgt = 32'h300; ifa.ImemRValid = 1'b1; ifa.ImemRData = dat(32'h200);
    #1;
    chk("brrv_state_before", 32'(dbg), 32'd1);
    @(negedge clk);
    br = 1'b0; ifa.ImemRValid = 1'b0;
    #1;
    chk("brrv_state", 32'(dbg), 32'd0);
    chk("brrv_valid", 32'(valid_f), 32'd0);
    chk("brrv_instr", instr_f, 32'h0);
    chk("brrv_req",   32'(ifa.ImemReq), 32'd1);
    chk("brrv_addr",  ifa.ImemAddr, 32'h300);
    @(negedge clk);

    // Back-to-back redirects: last target wins
    br = 1'b1; tgt = 32'h400;
    @(negedge clk);
    tgt = 32'h404;
    @(negedge clk);
    br = 1'b0; ifa.ImemAck = 1'b1;
    #1;
    chk("b2b_addr", ifa.ImemAddr, 32'h404);
    @(negedge clk);

    // Asynchronous reset in the middle of WAIT
    ifa.ImemAck = 1'b0;
    #1;
    chk("mid_state", 32'(dbg), 32'd1);
    chk("mid_pcf",   pcf, 32'h100);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RESET_PC near the top of the address space wraps to 0
    ifb.ImemAck = 1'b1;
    #1;
    chk("wrap_addr0", ifb.ImemAddr, 32'hFFFF_FFFC);
    chk("wrap_req0",  32'(ifb.ImemReq), 32'd1);
    @(negedge clk);
    ifb.ImemAck = 1'b0; ifb.ImemRValid = 1'b1; ifb.ImemRData = 32'h1234_5678;
    #1;
    @(negedge clk);
    ifb.ImemRValid = 1'b0;
    #1;
    chk("wrap_valid", 32'(b_valid_f), 32'd1);
    chk("wrap_pcf",   b_pcf, 32'hFFFF_FFFC);
    chk("wrap_instr", b_instr_f, 32'h1234_5678);
    chk("wrap_pcp4",  b_pcp4, 32'h0);
    chk("wrap_addr1", ifb.ImemAddr, 32'h0);
    chk("wrap_req1",  32'(ifb.ImemReq), 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the fetch/decode pipeline register and produces its InstrF input. It owns the fetch PC and drives a single-outstanding request/response instruction-memory port. It buffers one returned instruction and holds it under StallF. It redirects on taken branches, discarding any in-flight response, and presents an all-zero NOP with ValidF low whenever no instruction is available.

## Interface
- SIZE, 32: instruction and address width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- StallF  in  1  hold the presented instruction; do not consume the buffer.
- BranchTakenE  in  1  redirect request from execute.
- BranchTargetE  in  SIZE  redirect address, sampled when BranchTakenE=1.
- ImemReq  out  1  request valid.
- ImemAddr  out  SIZE  request address; always equals PC.
- ImemAck  in  1  request accepted this cycle; meaningful only when ImemReq=1.
- ImemRData  in  SIZE  response data.
- ImemRValid  in  1  response valid; earliest one cycle after the ack; responses return in order.
- InstrF  out  SIZE  buffered instruction when ValidF=1, else all zeros.
- PCF  out  SIZE  address of the instruction on InstrF.
- PCPlus4F  out  SIZE  PCF+4, modulo 2^SIZE.
- ValidF  out  1  InstrF holds a real instruction.
- MissF  out  1  equals ~ValidF; hazard unit uses it to bubble decode.

## Operation
- Registers:
  - PC: next request address.
  - ReqPC: address of the outstanding request.
  - InstrBuf / PCF / BufValid: presented instruction.
  - State: one of FETCH, WAIT, DRAIN.
- Consume event: BufValid=1 and StallF=0 at a clock edge. At that edge BufValid clears, unless a response loads the buffer at the same edge.
- FETCH (no request outstanding):
  - Drive ImemReq = ~BranchTakenE & (~BufValid | ~StallF).
  - On ImemReq & ImemAck: ReqPC<=PC, PC<=PC+4, go to WAIT.
- WAIT (one request outstanding; BufValid is always 0 here):
  - ImemReq=0.
  - On ImemRValid: InstrBuf<=ImemRData, PCF<=ReqPC, BufValid<=1, go to FETCH.
- DRAIN (outstanding response is stale):
  - ImemReq=0.
  - On ImemRValid: discard the data, go to FETCH.
- Redirect (BranchTakenE=1) has priority over everything else, including StallF:
  - ImemReq is forced to 0 that cycle.
  - PC<=BranchTargetE and BufValid<=0.
  - If state is WAIT and ImemRValid=0, go to DRAIN.
  - If state is WAIT and ImemRValid=1, drop the response and go to FETCH.
  - In DRAIN, the state is unchanged unless ImemRValid=1, which goes to FETCH.
  - In FETCH, stay in FETCH.
- Back-to-back redirects: the last target wins.
- Arithmetic:
  - All PC adds are SIZE-bit and wrap modulo 2^SIZE.
  - No alignment check; low bits pass through unchanged.
- At most one request is outstanding at any time.

## Timing
- Reset values (asynchronous, while RST_N=0): PC=RESET_PC, ReqPC=0, PCF=0, InstrBuf=0, BufValid=0, state=FETCH.
  - Outputs during reset: ImemReq=1 (FETCH with an empty buffer), ImemAddr=RESET_PC, InstrF=0, ValidF=0, MissF=1, PCPlus4F=4.
- Fetch latency: with ack at cycle n and rvalid at n+k (k≥1), InstrF/ValidF are valid from cycle n+k+1.
- Back-to-back fetch: a new request is issued in the same cycle the previous instruction is consumed. Peak throughput is one instruction per k+1 cycles.
- StallF=1 with ValidF=1: InstrF, PCF and ValidF are held indefinitely and no request is issued.
- Redirect latency: the request to the branch target is issued the cycle after BranchTakenE, or the cycle after the stale response is drained.
- Reset asserted mid-WAIT or mid-DRAIN: the state is abandoned immediately. The memory side must also be reset; the unit does not track a stale response across reset.

## Test plan
- Reset release, 1-cycle memory, StallF=0:
  - ImemAddr sequence is 0,4,8,...
  - ValidF first goes high 2 cycles after the first ack.
  - PCF/InstrF follow the memory contents, one instruction every 2 cycles.
- StallF held high for 5 cycles while ValidF=1:
  - InstrF/PCF are unchanged and ImemReq=0 throughout.
  - Releasing StallF issues the next request the same cycle.
- BranchTakenE with target 0x100 while in WAIT, with rvalid arriving 3 cycles later:
  - The returned data never appears on InstrF.
  - The next ImemAddr is 0x100 and the following ValidF shows PCF=0x100.
- BranchTakenE in the same cycle as ImemRValid: the response is dropped, state is FETCH, and the next ImemAddr equals the target.
- RESET_PC=32'hFFFF_FFFC: the first PCPlus4F is 0 and the second ImemAddr is 0 (wrap).
- RST_N asserted mid-WAIT: all outputs return to their reset values asynchronously, before the next clock edge.
